// File: rtl/inc_div_seq_if.sv
// Handshake and status bundle between the divide sequencer and its datapath/controller.
interface inc_div_seq_if;
  logic       start;
  logic       dprec;
  logic       rnd_en;
  logic       bzero;
  logic       fpuhold;
  logic       qin;
  logic       incovf;
  logic       altb;
  logic [3:0] incfunc;
  logic [3:0] nx_incfunc;
  logic [1:0] romsel;
  logic       busy;
  logic       done;
  logic       exp_adj;
  logic       dz;
  logic       q_nz;
  logic       rnd_ovf;

  modport master (
    output start, dprec, rnd_en, bzero, fpuhold, qin, incovf, altb,
    input  incfunc, nx_incfunc, romsel, busy, done, exp_adj, dz, q_nz, rnd_ovf
  );

  modport slave (
    input  start, dprec, rnd_en, bzero, fpuhold, qin, incovf, altb,
    output incfunc, nx_incfunc, romsel, busy, done, exp_adj, dz, q_nz, rnd_ovf
  );
endinterface

// File: rtl/inc_div_seq.sv
// Divide/remainder sequencer: walks align, quotient iterations, readout and optional
// rounding, issuing a function code per cycle and collecting status for the caller.
module inc_div_seq #(
  parameter int unsigned SP_STEPS = 26,
  parameter int unsigned DP_STEPS = 55
) (
  input logic          clk,
  input logic          reset,
  inc_div_seq_if.slave bus
);

  localparam int unsigned CntW  = 6;
  localparam int unsigned FuncW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ITER,
    S_HOLD,
    S_READ,
    S_ROUND,
    S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [FuncW-1:0] incfunc_q, incfunc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             exp_adj_q, exp_adj_d;
  logic             dz_q, dz_d;
  logic             q_nz_q, q_nz_d;
  logic             rnd_ovf_q, rnd_ovf_d;
  logic             dprec_q, dprec_d;
  logic             rnd_en_q, rnd_en_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      incfunc_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      exp_adj_q <= 1'b0;
      dz_q      <= 1'b0;
      q_nz_q    <= 1'b0;
      rnd_ovf_q <= 1'b0;
      dprec_q   <= 1'b0;
      rnd_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      incfunc_q <= incfunc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      exp_adj_q <= exp_adj_d;
      dz_q      <= dz_d;
      q_nz_q    <= q_nz_d;
      rnd_ovf_q <= rnd_ovf_d;
      dprec_q   <= dprec_d;
      rnd_en_q  <= rnd_en_d;
    end
  end

  // Next state and captured status; fpuhold leaves everything at its current value
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_adj_d = exp_adj_q;
    dz_d      = dz_q;
    q_nz_d    = q_nz_q;
    rnd_ovf_d = rnd_ovf_q;
    dprec_d   = dprec_q;
    rnd_en_d  = rnd_en_q;
    if (!bus.fpuhold) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            dprec_d  = bus.dprec;
            rnd_en_d = bus.rnd_en;
            dz_d     = bus.bzero;
            if (!bus.rnd_en) rnd_ovf_d = 1'b0;
            state_d = bus.bzero ? S_FIN : S_ALIGN;
          end
        end
        S_ALIGN: begin
          exp_adj_d = bus.altb;
          q_nz_d    = 1'b0;
          cnt_d     = dprec_q ? CntW'(DP_STEPS - 1) : CntW'(SP_STEPS - 1);
          state_d   = S_ITER;
        end
        S_ITER: begin
          q_nz_d = q_nz_q | bus.qin;
          if (cnt_q == '0) state_d = S_HOLD;
          else             cnt_d   = cnt_q - CntW'(1);
        end
        S_HOLD:  state_d = S_READ;
        S_READ:  state_d = rnd_en_q ? S_ROUND : S_FIN;
        S_ROUND: begin
          rnd_ovf_d = bus.incovf;
          state_d   = S_FIN;
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Registered outputs are decoded from the upcoming state
  always_comb begin
    incfunc_d = 4'h0;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FIN);
    unique case (state_d)
      S_ALIGN: incfunc_d = 4'hb;
      S_ITER:  incfunc_d = 4'h8;
      S_HOLD:  incfunc_d = 4'hb;
      S_READ:  incfunc_d = 4'h9;
      S_ROUND: incfunc_d = 4'h5;
      default: incfunc_d = 4'h0;
    endcase
  end

  assign bus.incfunc    = incfunc_q;
  assign bus.nx_incfunc = incfunc_d;
  assign bus.romsel     = 2'b00;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.exp_adj    = exp_adj_q;
  assign bus.dz         = dz_q;
  assign bus.q_nz       = q_nz_q;
  assign bus.rnd_ovf    = rnd_ovf_q;

endmodule

// File: tb/tb_inc_div_seq.sv
// Bench for inc_div_seq: operation-schedule reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inc_div_seq;
  localparam int unsigned SP = 26;
  localparam int unsigned DP = 55;

  localparam int PH_IDLE  = 0;
  localparam int PH_ALIGN = 1;
  localparam int PH_ITER  = 2;
  localparam int PH_HOLD  = 3;
  localparam int PH_READ  = 4;
  localparam int PH_ROUND = 5;
  localparam int PH_FIN   = 6;

  logic clk = 1'b0;
  logic reset;
  inc_div_seq_if bus ();

  inc_div_seq #(.SP_STEPS(SP), .DP_STEPS(DP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: the remaining phases of the operation in flight plus captured status
  int   sched[$];
  int   cur;
  logic m_dz, m_exp, m_qnz, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] code_of(input int ph);
    case (ph)
      PH_ALIGN: return 4'hb;
      PH_ITER:  return 4'h8;
      PH_HOLD:  return 4'hb;
      PH_READ:  return 4'h9;
      PH_ROUND: return 4'h5;
      default:  return 4'h0;
    endcase
  endfunction

  task automatic model_reset();
    sched.delete();
    cur   = PH_IDLE;
    m_dz  = 1'b0;
    m_exp = 1'b0;
    m_qnz = 1'b0;
    m_ovf = 1'b0;
  endtask

  function automatic int predict();
    if (bus.fpuhold)     return cur;
    if (cur == PH_IDLE)  return bus.start ? (bus.bzero ? PH_FIN : PH_ALIGN) : PH_IDLE;
    if (sched.size() > 0) return sched[0];
    return PH_IDLE;
  endfunction

  task automatic commit();
    int n;
    if (bus.fpuhold) return;
    if (cur == PH_ALIGN) begin m_exp = bus.altb; m_qnz = 1'b0; end
    if (cur == PH_ITER)  m_qnz = m_qnz | bus.qin;
    if (cur == PH_ROUND) m_ovf = bus.incovf;
    if (cur == PH_IDLE && bus.start) begin
      m_dz = bus.bzero;
      if (!bus.rnd_en) m_ovf = 1'b0;
      if (!bus.bzero) begin
        n = bus.dprec ? int'(DP) : int'(SP);
        sched.push_back(PH_ALIGN);
        repeat (n) sched.push_back(PH_ITER);
        sched.push_back(PH_HOLD);
        sched.push_back(PH_READ);
        if (bus.rnd_en) sched.push_back(PH_ROUND);
      end
      sched.push_back(PH_FIN);
    end
    cur = (sched.size() > 0) ? sched.pop_front() : PH_IDLE;
  endtask

  task automatic compare();
    chk("incfunc", 32'(bus.incfunc), 32'(code_of(cur)));
    chk("busy",    32'(bus.busy),    32'(cur != PH_IDLE));
    chk("done",    32'(bus.done),    32'(cur == PH_FIN));
    chk("dz",      32'(bus.dz),      32'(m_dz));
    chk("exp_adj", 32'(bus.exp_adj), 32'(m_exp));
    chk("q_nz",    32'(bus.q_nz),    32'(m_qnz));
    chk("rnd_ovf", 32'(bus.rnd_ovf), 32'(m_ovf));
    chk("romsel",  32'(bus.romsel),  32'(0));
  endtask

  // One clock: check the look-ahead code, advance the model at the edge, compare after
  task automatic tick();
    #1;
    if (!reset) chk("nx_incfunc", 32'(bus.nx_incfunc), 32'(code_of(predict())));
    @(posedge clk);
    if (reset) model_reset();
    else       commit();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.dprec = 1'b0; bus.rnd_en = 1'b0; bus.bzero = 1'b0;
    bus.fpuhold = 1'b0; bus.qin = 1'b0; bus.incovf = 1'b0; bus.altb = 1'b0;
  endtask

  // Launch one operation; k counts cycles after the start cycle until done is seen
  task automatic run_op(input logic dp, input logic rnd, input logic bz,
                        input int hold_at, input int hold_len, input int qin_at,
                        input logic spam, output int k);
    idle_inputs();
    bus.start = 1'b1; bus.dprec = dp; bus.rnd_en = rnd; bus.bzero = bz;
    bus.altb = 1'b1; bus.incovf = 1'b1;
    tick();
    bus.start = spam;
    bus.bzero = 1'b0;
    k = 0;
    while (!bus.done && k < 200) begin
      bus.qin     = (k == qin_at);
      bus.fpuhold = (k >= hold_at && k < hold_at + hold_len);
      tick();
      if (bus.fpuhold) begin
        chk("hold_incfunc", 32'(bus.incfunc), 32'h8);
        chk("hold_nx_incfunc", 32'(bus.nx_incfunc), 32'h8);
      end
      k++;
    end
    chk("done_seen", 32'(bus.done), 32'h1);
    bus.fpuhold = 1'b0;
    bus.qin     = 1'b0;
    tick();
    chk("after_fin_busy", 32'(bus.busy), 32'h0);
    chk("after_fin_done", 32'(bus.done), 32'h0);
    bus.start = 1'b0;
  endtask

  initial begin
    int k;
    idle_inputs();
    model_reset();
    reset = 1'b1;
    @(negedge clk);
    compare();
    chk("rst_incfunc", 32'(bus.incfunc), 32'h0);
    chk("rst_busy",    32'(bus.busy),    32'h0);
    reset = 1'b0;
    tick();

    // Single precision, no rounding: done in cycle 31 counting the start cycle
    run_op(1'b0, 1'b0, 1'b0, 1000, 0, 10, 1'b0, k);
    chk("sp_latency", 32'(k + 2), 32'd31);
    chk("sp_exp_adj", 32'(bus.exp_adj), 32'h1);
    chk("sp_q_nz",    32'(bus.q_nz),    32'h1);
    chk("sp_dz",      32'(bus.dz),      32'h0);

    // Double precision with rounding carry: done in cycle 61
    run_op(1'b1, 1'b1, 1'b0, 1000, 0, -1, 1'b0, k);
    chk("dp_latency", 32'(k + 2), 32'd61);
    chk("dp_rnd_ovf", 32'(bus.rnd_ovf), 32'h1);
    chk("dp_q_nz",    32'(bus.q_nz),    32'h0);

    // Divide by zero goes straight to FIN
    run_op(1'b0, 1'b0, 1'b1, 1000, 0, -1, 1'b0, k);
    chk("bz_latency", 32'(k), 32'd0);
    chk("bz_dz",      32'(bus.dz), 32'h1);

    // Three hold cycles mid-ITER delay done by exactly three cycles
    run_op(1'b0, 1'b0, 1'b0, 10, 3, -1, 1'b0, k);
    chk("hold_latency", 32'(k + 2), 32'd34);
    chk("hold_dz",      32'(bus.dz), 32'h0);

    // Start held high throughout, including FIN: only the first is accepted
    run_op(1'b0, 1'b0, 1'b0, 1000, 0, -1, 1'b1, k);
    chk("spam_latency", 32'(k + 2), 32'd31);

    // Reset in ITER: outputs clear immediately, no done, clean restart
    idle_inputs();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_busy",    32'(bus.busy),    32'h0);
    chk("rst_mid_incfunc", 32'(bus.incfunc), 32'h0);
    chk("rst_mid_done",    32'(bus.done),    32'h0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    run_op(1'b0, 1'b0, 1'b0, 1000, 0, -1, 1'b0, k);
    chk("post_rst_latency", 32'(k + 2), 32'd31);

    // Randomized traffic against the schedule model
    for (int i = 0; i < 4000; i++) begin
      bus.start   = ($urandom_range(3) == 0);
      bus.dprec   = 1'($urandom_range(1));
      bus.rnd_en  = 1'($urandom_range(1));
      bus.bzero   = ($urandom_range(7) == 0);
      bus.fpuhold = ($urandom_range(5) == 0);
      bus.qin     = ($urandom_range(15) == 0);
      bus.incovf  = 1'($urandom_range(1));
      bus.altb    = 1'($urandom_range(1));
      reset       = ($urandom_range(999) == 0);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inc_div_seq.md
INC_DIV_SEQ -- requirements
Module: inc_div_seq

Purpose: divide/remainder sequencer feeding the increment-module datapath; issues per-cycle function codes and consumes quotient/overflow status.

Interface
REQ-001 SHALL: parameter SP_STEPS, default 26, quotient iterations for single precision.
REQ-002 SHALL: parameter DP_STEPS, default 55, quotient iterations for double precision.
REQ-003 SHALL: clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL: start  input  1  one-cycle request to begin an operation; sampled only in IDLE.
REQ-006 SHALL: dprec  input  1  precision select, sampled with start (1 = double).
REQ-007 SHALL: rnd_en  input  1  rounding pass requested, sampled with start.
REQ-008 SHALL: bzero  input  1  divisor is zero, sampled with start.
REQ-009 SHALL: fpuhold  input  1  stall; freezes all state.
REQ-010 SHALL: qin  input  1  quotient bit produced by datapath this cycle.
REQ-011 SHALL: incovf  input  1  rounding carry-out from datapath.
REQ-012 SHALL: altb  input  1  dividend-high below divisor-high compare.
REQ-013 SHALL: incfunc  output  4  registered function code driving datapath this cycle.
REQ-014 SHALL: nx_incfunc  output  4  combinational code for the next cycle.
REQ-015 SHALL: romsel  output  2  constant 2'b00 (sequencer-driven code source).
REQ-016 SHALL: busy  output  1  high in every state except IDLE.
REQ-017 SHALL: done  output  1  one-cycle completion pulse.
REQ-018 SHALL: exp_adj  output  1  altb captured in ALIGN; exponent decrement needed.
REQ-019 SHALL: dz  output  1  divide-by-zero flag, valid with done.
REQ-020 SHALL: q_nz  output  1  OR of all qin captured during ITER, valid with done.
REQ-021 SHALL: rnd_ovf  output  1  incovf captured in ROUND, valid with done.

Function
REQ-022 SHALL: states IDLE, ALIGN, ITER, HOLD, READ, ROUND, FIN; incfunc per state 0x0, 0xb, 0x8, 0xb, 0x9, 0x5, 0x0.
REQ-023 SHALL: IDLE->ALIGN on start & !bzero; IDLE->FIN on start & bzero, setting dz=1.
REQ-024 SHALL: ALIGN lasts one cycle, captures exp_adj<=altb, loads 6-bit counter with DP_STEPS-1 or SP_STEPS-1 per dprec, clears q_nz.
REQ-025 SHALL: ITER decrements counter each cycle, q_nz<=q_nz|qin; exits to HOLD in the cycle counter equals 0 (total SP_STEPS/DP_STEPS ITER cycles).
REQ-026 SHALL: HOLD one cycle -> READ one cycle -> ROUND if rnd_en else FIN.
REQ-027 SHALL: ROUND one cycle, captures rnd_ovf<=incovf, -> FIN.
REQ-028 SHALL: FIN one cycle, done=1, -> IDLE; dz, exp_adj, q_nz, rnd_ovf hold until next accepted start.
REQ-029 SHALL: nx_incfunc equal the incfunc the register will hold after the next un-held edge; during fpuhold equal current incfunc.
REQ-030 SHALL: fpuhold=1 freeze state, counter, incfunc and all flags; done stays high if asserted when hold began; qin/incovf/altb ignored while held.
REQ-031 SHALL: start outside IDLE ignored; start in the FIN cycle ignored.
REQ-032 SHALL: latency start->done = 1+1+N+1+1+(rnd_en)+1 cycles excluding hold cycles (N = step count); bzero latency 1 cycle.
REQ-033 SHALL: rnd_ovf cleared on start when rnd_en=0.

Reset
REQ-034 SHALL: reset forces IDLE, counter 0, incfunc=0x0, busy=0, done=0, exp_adj=0, dz=0, q_nz=0, rnd_ovf=0, immediately and asynchronously.
REQ-035 SHALL: reset mid-operation abandon the operation with no done pulse; first start after reset release behaves as from power-up.

Verification
REQ-036 SHALL: SP, rnd_en=0, altb=1, qin=1 once -> ALIGN, 26 cycles incfunc=0x8, HOLD 0xb, READ 0x9, done at cycle 31 after start, exp_adj=1, q_nz=1.
REQ-037 SHALL: DP, rnd_en=1, incovf=1 in ROUND -> 55 ITER cycles, ROUND incfunc=0x5, done at cycle 61, rnd_ovf=1.
REQ-038 SHALL: start with bzero=1 -> FIN next cycle, done=1, dz=1, incfunc never 0x8.
REQ-039 SHALL: fpuhold 3 cycles mid-ITER -> counter and incfunc frozen, nx_incfunc=0x8, done delayed exactly 3 cycles.
REQ-040 SHALL: reset asserted in ITER -> outputs zero same cycle, no done; new SP start completes in 31 cycles.
REQ-041 SHALL: start pulsed while busy and in FIN -> ignored, single done per accepted start.
